srl32_seq: RTL and testbench
============================

// Module: srl32_seq
// PURPOSE
//  Multi-cycle right shifter; the shift-right counterpart of the combinational 32-bit left shifter.
//  Shifts operand a right by sh positions, one bit per clock. Fill is logical (zeros) or arithmetic (sign copies).
//  Reports a sticky carry-out flag for bits lost off the LSB end.
//  Sits in the ALU shift path, behind a start/done handshake.
// PARAMETERS
//  WIDTH  32  operand/result width in bits
//  SHW    5   shift-amount width; equals clog2(WIDTH)
// PORTS
//  clk    in   1       rising-edge clock
//  rst    in   1       synchronous reset, active-high
//  start  in   1       request; sampled only when busy=0
//  a      in   WIDTH   operand; captured on accepted start
//  sh     in   SHW     shift amount 0..WIDTH-1; captured on accepted start
//  arith  in   1       0=logical (zero fill), 1=arithmetic (fill with a[WIDTH-1]); captured on accepted start
//  busy   out  1       high in SHIFT and DONE states
//  done   out  1       one-cycle pulse; result valid
//  out    out  WIDTH   result register
//  cout   out  1       1 iff any shifted-out bit was 1
// BEHAVIOUR
//  Reset (rst=1 at a rising edge): state=IDLE, out=0, cout=0, done=0, busy=0, cnt=0.
//   Reset overrides every other input, including mid-operation; the operation in progress is aborted.
//   No done pulse is produced for an aborted operation.
//  FSM states: IDLE, SHIFT, DONE. busy = (state!=IDLE). done = (state==DONE).
//  IDLE, start=1 at edge: out<=a, cnt<=sh, mode<=arith, cout<=0, state<=SHIFT.
//  IDLE, start=0: hold all registers.
//  SHIFT, cnt!=0: out<=(mode ? out[W-1] : 1'b0) concatenated with out[W-1:1]; cout<=cout|out[0]; cnt<=cnt-1.
//  SHIFT, cnt==0: state<=DONE; out and cout are held.
//  DONE: state<=IDLE at the next edge. done is high for exactly this one cycle.
//  Latency: the start edge is E0. done is high in the cycle after edge E(sh+1).
//   sh=0 gives done one cycle after SHIFT is entered, with out=a and cout=0.
//  start while busy=1 (SHIFT or DONE) is ignored; it is not queued. a, sh and arith may change freely while busy.
//  out and cout hold the last result from DONE until the next accepted start. Bench samples them when done=1.
//  Final result equals a>>sh (logical) or $signed(a)>>>sh (arith). cout = |(a & ((1<<sh)-1)).
//  Back-to-back: the earliest next accept is in the first IDLE cycle after DONE. Minimum issue interval is sh+3 cycles.
// TESTING
//  1. a=0x8000_0001, sh=1, arith=0 -> done after E2; out=0x4000_0000, cout=1.
//  2. a=0x8000_0000, sh=31, arith=1 -> done after E32; out=0xFFFF_FFFF, cout=0.
//  3. a=0x1234_5678, sh=0, arith=1 -> done after E1; out=0x1234_5678, cout=0.
//  4. start for a=0xF0, sh=4; re-pulse start with a=0xFF, sh=1 while busy -> second start ignored; out=0x0F, cout=0, one done.
//  5. a=0xFFFF_FFFF, sh=8; assert rst at E3 -> next cycle busy=0, done=0, out=0, cout=0; no done ever; fresh start then works.
//  6. Random a/sh/arith, 1000 ops back-to-back -> each result matches the shift model and cout mask formula; done spacing=sh+3.

Source files
------------

// File: rtl/srl32_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | srl32_seq: multi-cycle right shifter, one bit per clock,         |
// | logical/arithmetic fill, sticky carry-out.  Rev 1.0              |
// +------------------------------------------------------------------+
module srl32_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   sh,
  input  logic             arith,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             cout
);

  localparam logic [SHW-1:0] C_CNT_ONE = {{(SHW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SHW-1:0]   r_cnt;
  logic             r_mode;
  logic [WIDTH-1:0] r_out;
  logic             r_cout;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_SHIFT;
      S_SHIFT: if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Result and carry stay frozen outside SHIFT so they remain readable after DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= '0;
      r_cout <= 1'b0;
      r_cnt  <= '0;
      r_mode <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_out  <= a;
            r_cnt  <= sh;
            r_mode <= arith;
            r_cout <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (r_cnt != '0) begin
            r_out  <= {(r_mode & r_out[WIDTH-1]), r_out[WIDTH-1:1]};
            r_cout <= r_cout | r_out[0];
            r_cnt  <= r_cnt - C_CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign out  = r_out;
  assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_srl32_seq.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_srl32_seq: directed and random checks of srl32_seq.  Rev 1.0  |
// +------------------------------------------------------------------+
module tb_srl32_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] a;
  logic [4:0]  sh;
  logic        arith;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic        cout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  srl32_seq #(.WIDTH(32), .SHW(5)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .sh    (sh),
    .arith (arith),
    .busy  (busy),
    .done  (done),
    .out   (out),
    .cout  (cout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one op (waits through DONE if needed), checks latency/result, returns done cycle.
  task automatic do_op(input logic [31:0] va, input logic [4:0] vsh, input logic varith,
                       input logic [31:0] exp_out, input logic exp_cout, output int done_cyc);
    int n;
    bit acc;
    bit got;
    a = va; sh = vsh; arith = varith; start = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 4 && !acc; i++) begin
      tick();
      if (busy && !done) acc = 1'b1;
    end
    start = 1'b0;
    chk("accept", {31'd0, acc}, 32'd1);
    n = 0;
    got = 1'b0;
    while (!got && n < 40) begin
      tick();
      n++;
      if (done) got = 1'b1;
    end
    done_cyc = cyc;
    chk("latency", n, {27'd0, vsh} + 32'd1);
    chk("out", out, exp_out);
    chk("cout", {31'd0, cout}, {31'd0, exp_cout});
  endtask

  initial begin
    int dc, prev_dc, ndone;
    logic [31:0]        ra, exp_o, mask;
    logic signed [31:0] sa;
    logic [4:0]         rsh;
    logic               rar;

    rst = 1'b1; start = 1'b0; a = '0; sh = '0; arith = 1'b0;
    tick(); tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_out",  out, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    rst = 1'b0;
    tick();

    do_op(32'h8000_0001, 5'd1,  1'b0, 32'h4000_0000, 1'b1, dc);
    do_op(32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 1'b0, dc);
    do_op(32'h1234_5678, 5'd0,  1'b1, 32'h1234_5678, 1'b0, dc);
    do_op(32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 1'b0, dc);
    do_op(32'h0000_00FF, 5'd4,  1'b1, 32'h0000_000F, 1'b1, dc);
    tick(); tick();
    chk("hold_out",  out, 32'h0000_000F);
    chk("hold_cout", {31'd0, cout}, 32'd1);
    chk("idle_busy", {31'd0, busy}, 32'd0);

    // Start while busy must be ignored.
    a = 32'hF0; sh = 5'd4; arith = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 32'hFF; sh = 5'd1; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) begin
        ndone++;
        chk("busy_out",  out, 32'h0F);
        chk("busy_cout", {31'd0, cout}, 32'd0);
      end
      tick();
    end
    chk("busy_ndone", ndone, 32'd1);

    // Reset mid-operation aborts without a done pulse.
    a = 32'hFFFF_FFFF; sh = 5'd8; arith = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_out",  out, 32'd0);
    chk("abort_cout", {31'd0, cout}, 32'd0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) ndone++;
      tick();
    end
    chk("abort_ndone", ndone, 32'd0);
    do_op(32'hFFFF_FFFF, 5'd8, 1'b0, 32'h00FF_FFFF, 1'b1, dc);

    // Random back-to-back ops; issue interval must equal sh+3.
    prev_dc = dc;
    for (int k = 0; k < 1000; k++) begin
      ra  = $urandom;
      rsh = 5'($urandom_range(0, 31));
      rar = 1'($urandom_range(0, 1));
      sa  = ra;
      exp_o = rar ? 32'(sa >>> rsh) : (ra >> rsh);
      mask  = (32'h1 << rsh) - 32'h1;
      do_op(ra, rsh, rar, exp_o, |(ra & mask), dc);
      chk("gap", dc - prev_dc, {27'd0, rsh} + 32'd3);
      prev_dc = dc;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
